// File: rtl/bytebeat_voice_mixer.sv
// rtl/bytebeat_voice_mixer.sv - mixes NUM_VOICES offset-binary PCM streams into one held sample per period
// Optional 1-LSB LFSR dither on the truncated bit when MIXER_DITHER_EN is defined.
module bytebeat_voice_mixer #(
    parameter int NUM_VOICES  = 8,
    parameter int SAMPLE_W    = 8,
    parameter int SAMPLE_DIV  = 32,
    parameter int ATTEN_SHIFT = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
    input  logic [NUM_VOICES-1:0]          voice_vld,
    output logic [NUM_VOICES-1:0]          voice_rdy,
    input  logic [NUM_VOICES-1:0]          voice_en,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_strobe,
    output logic                           mix_clip
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + IDX_W + 1;
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(SAMPLE_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(SAMPLE_W-1)));

    generate
        if (SAMPLE_DIV < NUM_VOICES + 2) begin : g_bad_div
            $error("bytebeat_voice_mixer: SAMPLE_DIV must be >= NUM_VOICES+2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

    state_t                    state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [SAMPLE_W-1:0]       slot_q [NUM_VOICES];
    logic [SAMPLE_W-1:0]       slot_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]     rdy_q, rdy_d;
    logic [NUM_VOICES-1:0]     en_snap_q, en_snap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [SAMPLE_W-1:0]       mix_out_q, mix_out_d;
    logic                      mix_strobe_q, mix_strobe_d;
    logic                      mix_clip_q, mix_clip_d;

    logic                      tick;
    logic [SAMPLE_W-1:0]       slot_sel;
    logic signed [SAMPLE_W-1:0] centered;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W:0]     pre;
    logic signed [ACC_W:0]     shifted;
    logic signed [ACC_W:0]     sat;
    logic                      clamped;

`ifdef MIXER_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
`endif

    assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        rdy_d = '1;
        for (int i = 0; i < NUM_VOICES; i++) begin
            slot_d[i] = (voice_vld[i] && rdy_q[i]) ? voice_data[i*SAMPLE_W +: SAMPLE_W] : slot_q[i];
        end

        // Flipping the MSB turns offset-binary into two's complement around midscale.
        slot_sel = slot_q[idx_q];
        centered = {~slot_sel[SAMPLE_W-1], slot_sel[SAMPLE_W-2:0]};
        term     = en_snap_q[idx_q] ? ACC_W'(centered) : '0;

        pre = (ACC_W+1)'(acc_q);
`ifdef MIXER_DITHER_EN
        pre = pre + {{ACC_W{1'b0}}, lfsr_q[0]};
        lfsr_d = tick ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
`endif
        shifted = pre >>> ATTEN_SHIFT;
        sat     = shifted;
        clamped = 1'b0;
        if (shifted > SAT_MAX) begin
            sat     = SAT_MAX;
            clamped = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat     = SAT_MIN;
            clamped = 1'b1;
        end

        state_d      = state_q;
        en_snap_d    = en_snap_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        mix_out_d    = mix_out_q;
        mix_strobe_d = 1'b0;
        mix_clip_d   = mix_clip_q;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    en_snap_d = voice_en;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + term;
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = S_EMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_EMIT: begin
                mix_out_d    = sat[SAMPLE_W-1:0] + MID;
                mix_strobe_d = 1'b1;
                mix_clip_d   = mix_clip_q | clamped;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            rdy_q        <= '0;
            en_snap_q    <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            mix_out_q    <= MID;
            mix_strobe_q <= 1'b0;
            mix_clip_q   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                slot_q[i] <= MID;
            end
`ifdef MIXER_DITHER_EN
            lfsr_q       <= 16'hACE1;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            rdy_q        <= rdy_d;
            en_snap_q    <= en_snap_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            mix_out_q    <= mix_out_d;
            mix_strobe_q <= mix_strobe_d;
            mix_clip_q   <= mix_clip_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                slot_q[i] <= slot_d[i];
            end
`ifdef MIXER_DITHER_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign voice_rdy  = rdy_q;
    assign mix_out    = mix_out_q;
    assign mix_strobe = mix_strobe_q;
    assign mix_clip   = mix_clip_q;

endmodule
